// File: rtl/disp_pkg.sv
// disp_pkg
//   Shared definitions for the multiplexed display scan controller:
//   default geometry, the "all digits dark" enable pattern and the FSM
//   state type. Imported by display_scan_ctrl.
package disp_pkg;

  localparam int N_DIGITS_DEF    = 4;
  localparam int REFRESH_DIV_DEF = 50000;
  localparam int MAX_DIGITS      = 8;

  // Digit enables are active-low; all ones means every digit is dark.
  // Sized for the largest supported display and sliced by the user.
  localparam logic [MAX_DIGITS-1:0] AN_OFF = '1;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

endpackage

// File: rtl/scan_tick_gen.sv
// scan_tick_gen
//   Slot counter for the display scan. Counts 0..REFRESH_DIV-1 while run
//   is high and wraps; clr forces the next count to 0 and takes priority.
//
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   run        : advance the counter this cycle
//   clr        : restart the slot (next count = 0)
//   last       : current count is REFRESH_DIV-1 (slot ends at this edge)
//   dead_nxt   : the count after this edge is 0, i.e. the coming cycle is
//                the dead (anti-ghosting) cycle of a slot
module scan_tick_gen #(
  parameter int REFRESH_DIV = 4,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run,
  input  logic clr,
  output logic last,
  output logic dead_nxt
);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  assign last = (cnt == CNT_W'(REFRESH_DIV - 1));

  always_comb begin
    cnt_nxt = cnt;
    if (clr) begin
      cnt_nxt = '0;
    end else if (run) begin
      cnt_nxt = last ? '0 : cnt + CNT_W'(1);
    end
  end

  // The parent registers its outputs from next-state values, so it needs
  // to know about the dead cycle one edge ahead.
  assign dead_nxt = (cnt_nxt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

endmodule

// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl
//   Time-multiplexed scan controller sharing one hex-to-7-segment decoder
//   between N_DIGITS digits. Holds a frame of nibbles (shadow), lights one
//   digit per refresh slot, and only swaps in a new frame at a frame
//   boundary so a displayed frame never tears.
//
// Optional build macro: DISPLAY_LZ_BLANK_EN
//   When defined, leading-zero digits (k>0 with that nibble and every
//   higher nibble zero) are blanked in addition to blank_mask.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : producer valid
//   ready       : controller can accept a frame
//   value       : frame nibbles, digit k = value[4k+3:4k], digit 0 rightmost
//   blank_mask  : 1 = digit forced dark, captured together with value
//   nibble      : selected nibble to the shared decoder
//   an          : digit enables, active-low, one-hot-low when lit
//   frame_done  : one-cycle pulse after the last digit's slot ends
//
// Handshake: a frame transfers on any rising edge where load && ready.
//   value/blank_mask are sampled only on that edge; load while ready is
//   low is ignored. In IDLE the frame goes straight to the shadow. In SCAN
//   it parks in the pending buffer and ready drops until the frame
//   boundary moves it to the shadow; an accept on the boundary cycle
//   itself bypasses pending and ready stays high.
module display_scan_ctrl
  import disp_pkg::*;
#(
  parameter int N_DIGITS    = N_DIGITS_DEF,
  parameter int REFRESH_DIV = REFRESH_DIV_DEF,
  parameter int CNT_W       = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  output logic                  ready,
  input  logic [4*N_DIGITS-1:0] value,
  input  logic [N_DIGITS-1:0]   blank_mask,
  output logic [3:0]            nibble,
  output logic [N_DIGITS-1:0]   an,
  output logic                  frame_done
);

  localparam int W     = 4 * N_DIGITS;
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

  state_t              state, state_nxt;
  logic [IDX_W-1:0]    idx, idx_nxt;
  logic [W-1:0]        shadow, shadow_nxt;
  logic [N_DIGITS-1:0] blank_sh, blank_sh_nxt;
  logic [W-1:0]        pend, pend_nxt;
  logic [N_DIGITS-1:0] pend_blank, pend_blank_nxt;
  logic                pend_flag, pend_flag_nxt;

  logic                run, clr, last, dead_nxt;
  logic                accept, boundary;
  logic [N_DIGITS-1:0] blank_eff_nxt;
  logic [3:0]          nibble_nxt;
  logic [N_DIGITS-1:0] an_nxt;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV),
    .CNT_W       (CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .run      (run),
    .clr      (clr),
    .last     (last),
    .dead_nxt (dead_nxt)
  );

  assign accept   = load && ready;
  assign boundary = (state == SCAN) && last && (idx == LAST_IDX);
  assign run      = (state == SCAN);

  // Next-state logic. A set pending flag implies ready is low, so accept
  // and a pending frame never compete at the same boundary.
  always_comb begin
    state_nxt      = state;
    idx_nxt        = idx;
    shadow_nxt     = shadow;
    blank_sh_nxt   = blank_sh;
    pend_nxt       = pend;
    pend_blank_nxt = pend_blank;
    pend_flag_nxt  = pend_flag;
    clr            = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt    = SCAN;
          shadow_nxt   = value;
          blank_sh_nxt = blank_mask;
          idx_nxt      = '0;
          clr          = 1'b1;
        end
      end
      SCAN: begin
        if (last) begin
          idx_nxt = (idx == LAST_IDX) ? '0 : idx + IDX_W'(1);
        end
        if (boundary && accept) begin
          shadow_nxt   = value;
          blank_sh_nxt = blank_mask;
        end else if (boundary && pend_flag) begin
          shadow_nxt    = pend;
          blank_sh_nxt  = pend_blank;
          pend_flag_nxt = 1'b0;
        end else if (accept) begin
          pend_nxt       = value;
          pend_blank_nxt = blank_mask;
          pend_flag_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

`ifdef DISPLAY_LZ_BLANK_EN
  // Walk down from the top digit; a digit is a leading zero while every
  // nibble from it upward is zero. Digit 0 always shows.
  function automatic logic [N_DIGITS-1:0] lz_mask(input logic [W-1:0] v);
    logic run_zero;
    lz_mask  = '0;
    run_zero = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      run_zero   = run_zero && (v[4*k +: 4] == 4'h0);
      lz_mask[k] = run_zero;
    end
  endfunction

  // The shadow only changes when a frame is loaded into it, so this mask
  // is effectively computed at that load and held in the registered an.
  assign blank_eff_nxt = blank_sh_nxt | lz_mask(shadow_nxt);
`else
  assign blank_eff_nxt = blank_sh_nxt;
`endif

  // Outputs are registered from next-state values so nibble/an line up
  // with the slot that the state registers enter at the same edge.
  always_comb begin
    nibble_nxt = 4'h0;
    an_nxt     = AN_OFF[N_DIGITS-1:0];
    if (state_nxt == SCAN) begin
      nibble_nxt = shadow_nxt[4*idx_nxt +: 4];
      if (!dead_nxt && !blank_eff_nxt[idx_nxt]) begin
        an_nxt = ~(N_DIGITS'(1) << idx_nxt);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      shadow     <= '0;
      blank_sh   <= '0;
      pend       <= '0;
      pend_blank <= '0;
      pend_flag  <= 1'b0;
      nibble     <= 4'h0;
      an         <= AN_OFF[N_DIGITS-1:0];
      ready      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      idx        <= idx_nxt;
      shadow     <= shadow_nxt;
      blank_sh   <= blank_sh_nxt;
      pend       <= pend_nxt;
      pend_blank <= pend_blank_nxt;
      pend_flag  <= pend_flag_nxt;
      nibble     <= nibble_nxt;
      an         <= an_nxt;
      ready      <= !pend_flag_nxt;
      frame_done <= boundary;
    end
  end

endmodule
